// File: rtl/ad7928_slave_model.sv
// AD7928 responder model: oversamples the master's SPI pins in the clk domain,
// returns {0, addr, sample} frames and applies WRITE control words on CS rise.
// Optional build macro AD7928_SLAVE_RAMP_EN replaces ch_data_* with internal
// per-channel ramp counters.
module ad7928_slave_model #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [2:0]  RESET_ADDR  = 3'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        adc_cs_n,
    input  logic        adc_sclk,
    input  logic        adc_din,
    output logic        adc_dout,
    input  logic [11:0] ch_data_0,
    input  logic [11:0] ch_data_1,
    input  logic [11:0] ch_data_2,
    input  logic [11:0] ch_data_3,
    input  logic [11:0] ch_data_4,
    input  logic [11:0] ch_data_5,
    input  logic [11:0] ch_data_6,
    input  logic [11:0] ch_data_7,
    output logic [11:0] ctrl_word,
    output logic [2:0]  cur_addr,
    output logic        frame_done,
    output logic        frame_err
);

    localparam int unsigned DATA_W = 12;
    localparam int unsigned WORD_W = 16;
    localparam int unsigned CTRL_W = 12;
    localparam int unsigned CNT_W  = 4;
    // PM = 2'b11 (normal operation), CODING = 1 (straight binary)
    localparam logic [CTRL_W-1:0] CTRL_RESET = 12'h031;
    localparam logic [1:0]        PM_SHUTDOWN = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [WORD_W-1:0]   out_sr_q, out_sr_d;
    logic [WORD_W-1:0]   in_sr_q, in_sr_d;
    logic                dout_q, dout_d;
    logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
    logic [2:0]          addr_q, addr_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic [2:0]          pins_s;
    logic                cs_s, sclk_s, din_s;
    logic                cs_prev_q, sclk_prev_q;
    logic                cs_fall, cs_rise, sclk_fall;
    logic [DATA_W-1:0]   raw_sample;
    logic [DATA_W-1:0]   sample;

    // Pin synchronizers (bypassed when the master already runs on clk)
    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign pins_s = {adc_cs_n, adc_sclk, adc_din};
        end else begin : g_sync
            logic [2:0] sync_q [SYNC_STAGES];
            // Shift raw pins through the synchronizer chain
            always_ff @(posedge clk) begin
                sync_q[0] <= {adc_cs_n, adc_sclk, adc_din};
                for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                    sync_q[i] <= sync_q[i-1];
                end
            end
            assign pins_s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    assign cs_s   = pins_s[2];
    assign sclk_s = pins_s[1];
    assign din_s  = pins_s[0];

    // Edge-detect history; tracks the pins through reset so no event fires on release
    always_ff @(posedge clk) begin
        cs_prev_q   <= cs_s;
        sclk_prev_q <= sclk_s;
    end

    assign cs_fall   = cs_prev_q & ~cs_s;
    assign cs_rise   = ~cs_prev_q & cs_s;
    assign sclk_fall = sclk_prev_q & ~sclk_s;

`ifdef AD7928_SLAVE_RAMP_EN
    logic [DATA_W-1:0] ramp_q [8];
    logic [2:0]        frame_addr_q;
    logic              unused_ch_data;

    assign unused_ch_data = ^{ch_data_0, ch_data_1, ch_data_2, ch_data_3,
                              ch_data_4, ch_data_5, ch_data_6, ch_data_7};

    // Per-channel ramps advance after each completed frame that returned them
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned ch = 0; ch < 8; ch++) begin
                ramp_q[ch] <= {3'(ch), 9'd0};
            end
            frame_addr_q <= RESET_ADDR;
        end else begin
            if (state_q == IDLE && cs_fall) begin
                frame_addr_q <= addr_q;
            end
            if (done_d) begin
                ramp_q[frame_addr_q] <= ramp_q[frame_addr_q] + 12'd1;
            end
        end
    end

    assign raw_sample = ramp_q[addr_q];
`else
    // Channel mux for the conversion snapshot
    always_comb begin
        raw_sample = '0;
        case (addr_q)
            3'd0: raw_sample = ch_data_0;
            3'd1: raw_sample = ch_data_1;
            3'd2: raw_sample = ch_data_2;
            3'd3: raw_sample = ch_data_3;
            3'd4: raw_sample = ch_data_4;
            3'd5: raw_sample = ch_data_5;
            3'd6: raw_sample = ch_data_6;
            3'd7: raw_sample = ch_data_7;
            default: raw_sample = '0;
        endcase
    end
`endif

    // Apply power-down and output coding from the control register
    always_comb begin
        sample = raw_sample;
        if (ctrl_q[5:4] == PM_SHUTDOWN) begin
            sample = '0;
        end else if (!ctrl_q[0]) begin
            sample = raw_sample ^ 12'h800;
        end
    end

    // Frame FSM: next-state and next register values
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        out_sr_d  = out_sr_q;
        in_sr_d   = in_sr_q;
        dout_d    = dout_q;
        ctrl_d    = ctrl_q;
        addr_d    = addr_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            IDLE: begin
                dout_d = 1'b0;
                if (cs_fall) begin
                    out_sr_d  = {1'b0, addr_q, sample};
                    dout_d    = 1'b0;
                    bit_cnt_d = '0;
                    in_sr_d   = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    err_d   = 1'b1;
                    dout_d  = 1'b0;
                    state_d = IDLE;
                end else if (sclk_fall) begin
                    in_sr_d = {in_sr_q[WORD_W-2:0], din_s};
                    if (bit_cnt_q == 4'd15) begin
                        state_d = DONE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        out_sr_d  = {out_sr_q[WORD_W-2:0], 1'b0};
                        dout_d    = out_sr_q[WORD_W-2];
                    end
                end
            end
            DONE: begin
                if (cs_rise) begin
                    if (in_sr_q[15]) begin
                        ctrl_d = in_sr_q[15:4];
                        addr_d = in_sr_q[12:10];
                    end
                    done_d  = 1'b1;
                    dout_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                dout_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and register update
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            out_sr_q  <= '0;
            in_sr_q   <= '0;
            dout_q    <= 1'b0;
            ctrl_q    <= CTRL_RESET;
            addr_q    <= RESET_ADDR;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            out_sr_q  <= out_sr_d;
            in_sr_q   <= in_sr_d;
            dout_q    <= dout_d;
            ctrl_q    <= ctrl_d;
            addr_q    <= addr_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign adc_dout   = dout_q;
    assign ctrl_word  = ctrl_q;
    assign cur_addr   = addr_q;
    assign frame_done = done_q;
    assign frame_err  = err_q;

endmodule

// File: tb/tb_ad7928_slave_model.sv
// Randomized bench for ad7928_slave_model against a frame-level device model.
module tb_ad7928_slave_model;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        adc_cs_n = 1'b1;
    logic        adc_sclk = 1'b1;
    logic        adc_din = 1'b0;
    logic        adc_dout;
    logic [11:0] ch [8];
    logic [11:0] ctrl_word;
    logic [2:0]  cur_addr;
    logic        frame_done;
    logic        frame_err;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;
    int err_cnt  = 0;

    // Device model state
    logic [11:0] m_ctrl;
    logic [2:0]  m_addr;
    logic [11:0] m_ramp [8];

    ad7928_slave_model #(.SYNC_STAGES(2), .RESET_ADDR(3'd0)) dut (
        .clk(clk), .rst(rst),
        .adc_cs_n(adc_cs_n), .adc_sclk(adc_sclk), .adc_din(adc_din),
        .adc_dout(adc_dout),
        .ch_data_0(ch[0]), .ch_data_1(ch[1]), .ch_data_2(ch[2]), .ch_data_3(ch[3]),
        .ch_data_4(ch[4]), .ch_data_5(ch[5]), .ch_data_6(ch[6]), .ch_data_7(ch[7]),
        .ctrl_word(ctrl_word), .cur_addr(cur_addr),
        .frame_done(frame_done), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    // Count cycles each pulse output is high
    always @(negedge clk) begin
        if (frame_done) done_cnt++;
        if (frame_err)  err_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic void model_reset();
        m_ctrl = 12'h031;
        m_addr = 3'd0;
        for (int c = 0; c < 8; c++) m_ramp[c] = 12'(c) << 9;
    endfunction

    // Word the device should return for the next frame
    function automatic logic [15:0] model_word();
        logic [11:0] s;
`ifdef AD7928_SLAVE_RAMP_EN
        s = m_ramp[m_addr];
`else
        s = ch[m_addr];
`endif
        if (m_ctrl[5:4] == 2'b10) s = 12'h000;
        else if (m_ctrl[0] == 1'b0) s = s ^ 12'h800;
        return {1'b0, m_addr, s};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        tick(4);
        rst = 1'b0;
        tick(2);
        model_reset();
    endtask

    // One SPI frame with n_falls SCLK falling edges; checks result against model
    task automatic frame(input string tag, input logic [15:0] din_w, input int n_falls,
                         output logic [15:0] got);
        logic [15:0] exp;
        int d0, e0, nb;
        exp = model_word();
        got = '0;
        d0 = done_cnt;
        e0 = err_cnt;
        adc_cs_n = 1'b0;
        tick(8);
        for (int k = 0; k < n_falls; k++) begin
            if (k < 16) got[15-k] = adc_dout;
            adc_din = (k < 16) ? din_w[15-k] : 1'b0;
            tick(4);
            adc_sclk = 1'b0;
            tick(8);
            adc_sclk = 1'b1;
            tick(4);
        end
        tick(8);
        adc_cs_n = 1'b1;
        tick(10);
        if (n_falls >= 16) begin
            check({tag, " dout"}, 32'(got), 32'(exp));
            check({tag, " done"}, 32'(done_cnt - d0), 32'd1);
            check({tag, " err"}, 32'(err_cnt - e0), 32'd0);
            m_ramp[m_addr] = m_ramp[m_addr] + 12'd1;
            if (din_w[15]) begin
                m_ctrl = din_w[15:4];
                m_addr = din_w[12:10];
            end
        end else begin
            nb = 16 - n_falls;
            check({tag, " dout_part"}, 32'(got >> nb), 32'(exp >> nb));
            check({tag, " done"}, 32'(done_cnt - d0), 32'd0);
            check({tag, " err"}, 32'(err_cnt - e0), 32'd1);
        end
        check({tag, " ctrl"}, 32'(ctrl_word), 32'(m_ctrl));
        check({tag, " addr"}, 32'(cur_addr), 32'(m_addr));
        check({tag, " dout_idle"}, 32'(adc_dout), 32'd0);
        tick(8);
    endtask

    initial begin
        logic [15:0] got;
        int d0, e0, nf;
        for (int c = 0; c < 8; c++) ch[c] = 12'h000;
        do_reset();

        check("rst dout", 32'(adc_dout), 32'd0);
        check("rst ctrl", 32'(ctrl_word), 32'h031);
        check("rst addr", 32'(cur_addr), 32'd0);
        check("rst done", 32'(frame_done), 32'd0);
        check("rst err", 32'(frame_err), 32'd0);

        // Directed sequence
        ch[0] = 12'hABC;
        frame("f8310", 16'h8310, 16, got);
`ifndef AD7928_SLAVE_RAMP_EN
        check("lit 0ABC", 32'(got), 32'h0ABC);
`endif
        check("lit addr0", 32'(cur_addr), 32'd0);
        frame("f9F10", 16'h9F10, 16, got);
        check("lit addr7", 32'(cur_addr), 32'd7);
        ch[7] = 12'h123;
        frame("f9F00", 16'h9F00, 16, got);
`ifndef AD7928_SLAVE_RAMP_EN
        check("lit 7123", 32'(got), 32'h7123);
`endif
        frame("coding0", 16'h0000, 16, got);
`ifndef AD7928_SLAVE_RAMP_EN
        check("lit 7923", 32'(got), 32'h7923);
`endif
        frame("abort9", 16'h9410, 9, got);
        check("lit abort addr", 32'(cur_addr), 32'd7);
        check("lit abort ctrl", 32'(ctrl_word), 32'h9F0);
        frame("f8210", 16'h8210, 16, got);
        ch[0] = 12'hFFF;
        frame("pmdown", 16'h0000, 16, got);
        check("lit pm 0000", 32'(got), 32'h0000);

        // Reset in the middle of a frame
        d0 = done_cnt;
        e0 = err_cnt;
        adc_cs_n = 1'b0;
        tick(8);
        for (int k = 0; k < 7; k++) begin
            adc_din = 1'b1;
            tick(4);
            adc_sclk = 1'b0;
            tick(8);
            adc_sclk = 1'b1;
            tick(4);
        end
        rst = 1'b1;
        tick(3);
        check("midrst dout", 32'(adc_dout), 32'd0);
        check("midrst addr", 32'(cur_addr), 32'd0);
        check("midrst ctrl", 32'(ctrl_word), 32'h031);
        rst = 1'b0;
        model_reset();
        tick(4);
        adc_cs_n = 1'b1;
        tick(10);
        check("midrst done", 32'(done_cnt - d0), 32'd0);
        check("midrst err", 32'(err_cnt - e0), 32'd0);
        ch[0] = 12'hABC;
        frame("postrst", 16'h0000, 16, got);
`ifndef AD7928_SLAVE_RAMP_EN
        check("lit postrst", 32'(got), 32'h0ABC);
`endif

`ifdef AD7928_SLAVE_RAMP_EN
        do_reset();
        frame("ramp sel2", 16'h8B10, 16, got);
        frame("ramp a", 16'h0000, 16, got);
        check("lit ramp 400", 32'(got), 32'h2400);
        frame("ramp b", 16'h0000, 16, got);
        check("lit ramp 401", 32'(got), 32'h2401);
        frame("ramp c", 16'h0000, 16, got);
        check("lit ramp 402", 32'(got), 32'h2402);
`endif

        // Randomized frames: random control words, samples, aborts and extra SCLKs
        for (int i = 0; i < 60; i++) begin
            for (int c = 0; c < 8; c++) ch[c] = 12'($urandom);
            if ($urandom_range(0, 4) == 0) nf = $urandom_range(1, 15);
            else nf = $urandom_range(16, 18);
            frame("rand", 16'($urandom), nf, got);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ad7928_slave_model.md
Name: ad7928_slave_model

Overview:
- Synthesizable responder model of the AD7928 8-channel 12-bit SPI ADC, i.e. the device end of our ADC interface.
- Driven by the ADC master's adc_cs_n/adc_sclk/adc_din; returns adc_dout frames built from per-channel 12-bit sample inputs.
- Used for on-FPGA loopback and bench bring-up of the oscilloscope capture path without the physical ADC.
- Oversamples the SPI pins in the clk domain; honours the control register semantics (WRITE, ADD, PM, CODING).

Parameters:
SYNC_STAGES, 2, number of synchronizer flops on adc_cs_n/adc_sclk/adc_din (0 = inputs already in clk domain)
RESET_ADDR, 3'd0, channel address loaded at reset

Ports:
clk  in  1  system clock; must be ≥ (SYNC_STAGES+3)×2 × SCLK frequency
rst  in  1  synchronous, active-high reset
adc_cs_n  in  1  chip select from master, active low
adc_sclk  in  1  serial clock from master, idles high
adc_din  in  1  control word from master, MSB first
adc_dout  out  1  serial result to master, MSB first
ch_data_0 .. ch_data_7  in  12 each  straight-binary sample value per channel
ctrl_word  out  12  last applied control word (bits 15..4 of frame)
cur_addr  out  3  channel that the next frame will return
frame_done  out  1  one-cycle pulse, complete 16-edge frame ended
frame_err  out  1  one-cycle pulse, CS deasserted before 16th falling edge

Behaviour:
- Reset (sync, rst=1): adc_dout=0, ctrl_word=12'h000 except PM field=2'b11 and CODING=1, cur_addr=RESET_ADDR, frame_done=0, frame_err=0, FSM=IDLE, bit counter=0.
- Input path: SYNC_STAGES flops per pin, then one edge-detect register; events = CS fall, CS rise, SCLK fall.
- FSM states: IDLE, SHIFT, DONE.
- IDLE: on CS fall, latch out_word = {1'b0, cur_addr, sample}; sample = ch_data[cur_addr] (conversion snapshot, held for the whole frame); drive adc_dout=out_word[15] same cycle; bit_cnt=0; go SHIFT.
- SHIFT, each SCLK fall: shift adc_din into in_shift (MSB first); bit_cnt+1; if bit_cnt<15 after increment, drive adc_dout=out_word[15-bit_cnt]. After 16th fall: go DONE, adc_dout holds DB0.
- DONE, on CS rise: if in_shift[15] (WRITE)=1, then ctrl_word<=in_shift[15:4], cur_addr<=in_shift[12:10]; else registers unchanged. frame_done pulses 1 cycle; adc_dout=0; go IDLE.
- SHIFT, CS rise before 16 falls: frame discarded, no register update, frame_err pulses 1 cycle, adc_dout=0, go IDLE.
- Extra SCLK falls in DONE: ignored, adc_dout holds.
- CS fall while not IDLE: not legal, since CS rise always returns to IDLE first.
- Address pipeline: address written in frame N selects the data returned in frame N+1, as on the real device.
- Coding: ctrl CODING=1 returns sample unchanged. CODING=0 returns two's complement: sample ^ 12'h800.
- PM: 2'b10 (full shutdown) applied → following frames return 12'h000 data but the correct address bits. Any other PM value returns normal data.
- RANGE, SHADOW, SEQ bits stored in ctrl_word, no effect on data.
- rst mid-frame: immediate return to IDLE, registers to reset values, no pulses.
- adc_dout=0 whenever CS high.

Optional Feature:
AD7928_SLAVE_RAMP_EN
- Defined: sample source replaced by internal 12-bit per-channel counters ramp[ch], reset to {ch,9'd0}. A channel's counter increments by 1 (wrapping 12'hFFF→0) after each completed frame that returned it. ch_data_* are ignored.
- Undefined: samples come from ch_data_*; no counters synthesized.

Test Plan:
- Reset, ch_data_0=12'hABC, frame with din=16'h8310 → dout bits = 0,000,ABC; frame_done=1; cur_addr=0 then 0.
- Frame din=16'h9F10 (WRITE, ADD=3'b111), then frame with ch_data_7=12'h123 → second frame dout=16'h7123; cur_addr=7.
- CODING=0 written (din=16'h9F00), next frame with ch_data_7=12'h123 → dout data=12'h923.
- CS raised after 9 SCLK falls with din WRITE=1, ADD=5 → frame_err pulse, cur_addr unchanged, ctrl_word unchanged, adc_dout=0.
- PM=2'b10 written (din=16'h8210), next frame with ch_data_0=12'hFFF → dout=16'h0000.
- rst asserted during bit 7 → adc_dout=0, cur_addr=RESET_ADDR; next full frame behaves as after power-up. With RAMP_EN, three frames on ch 2 return 12'h400, 12'h401, 12'h402.
